// File: rtl/multi_sync_edge_pkg.sv
// Shared constants and helpers for the multi-channel level synchroniser.
// Optional stability filter is compiled in with MULTI_SYNC_FILTER_EN.
package cdc_sync_pkg;

  localparam int DEFAULT_SYNC_DEPTH = 2;
  localparam int DEFAULT_FILTER     = 4;

  // Width of a counter that must hold values 0..filter-1 plus headroom for filter itself.
  function automatic int cnt_w(input int filter);
    return (filter < 1) ? 1 : $clog2(filter + 1);
  endfunction

endpackage

// File: rtl/multi_sync_edge_if.sv
// Level-crossing bundle: async levels in, synchronised level and edge pulses out.
// No handshake: async_i is sampled every clock; outputs are valid every cycle after reset.
interface multi_sync_edge_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] async_i;
  logic [WIDTH-1:0] level_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             any_edge_o;

  modport master (
    output async_i,
    input  level_o, rise_o, fall_o, any_edge_o
  );

  modport slave (
    input  async_i,
    output level_o, rise_o, fall_o, any_edge_o
  );
endinterface

// File: rtl/multi_sync_edge_sync_chan.sv
// One channel: DEPTH-flop synchroniser, optional stability filter
// (MULTI_SYNC_FILTER_EN) and registered rise/fall pulses.
module sync_chan
  import cdc_sync_pkg::*;
#(
  parameter int   DEPTH   = DEFAULT_SYNC_DEPTH,
  parameter int   FILTER  = DEFAULT_FILTER,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_chan: DEPTH must be at least 2");
  end
  if (FILTER < 1) begin : g_bad_filter
    $error("sync_chan: FILTER must be at least 1");
  end

  logic [DEPTH-1:0] sync_q;
  logic             level_cur;
  logic             level_nxt;
  logic             rise_q;
  logic             fall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {DEPTH{RST_VAL}};
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], async_i};
    end
  end

`ifdef MULTI_SYNC_FILTER_EN
  localparam int CW = cnt_w(FILTER);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;

  // cnt counts consecutive cycles the synced value has disagreed with level_q.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[DEPTH-1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER - 1)) begin
      level_d = sync_q[DEPTH-1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      level_q <= RST_VAL;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_cur = level_q;
  assign level_nxt = level_d;
`else
  // The last stage is the output; the stage before it is its next value.
  assign level_cur = sync_q[DEPTH-1];
  assign level_nxt = sync_q[DEPTH-2];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= level_nxt & ~level_cur;
      fall_q <= ~level_nxt & level_cur;
    end
  end

  assign level_o = level_cur;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/multi_sync_edge.sv
// WIDTH independent level synchronisers with edge pulses; not for multi-bit buses.
// Stability filter is enabled by defining MULTI_SYNC_FILTER_EN.
module multi_sync_edge
  import cdc_sync_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = DEFAULT_SYNC_DEPTH,
  parameter int               FILTER  = DEFAULT_FILTER,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rstn,
  multi_sync_edge_if.slave   bus
);

  if (WIDTH < 1) begin : g_bad_width
    $error("multi_sync_edge: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] level_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_chan #(
      .DEPTH   (DEPTH),
      .FILTER  (FILTER),
      .RST_VAL (RST_VAL[i])
    ) u_chan (
      .clk     (clk),
      .rstn    (rstn),
      .async_i (bus.async_i[i]),
      .level_o (level_w[i]),
      .rise_o  (rise_w[i]),
      .fall_o  (fall_w[i])
    );
  end

  assign bus.level_o    = level_w;
  assign bus.rise_o     = rise_w;
  assign bus.fall_o     = fall_w;
  assign bus.any_edge_o = |(rise_w | fall_w);

endmodule

// File: tb/tb_multi_sync_edge.sv
// Bench for multi_sync_edge: two instances (DEPTH 2 and 4) fed the same inputs,
// checked against a sliding-window reference; follows MULTI_SYNC_FILTER_EN.
module tb_multi_sync_edge;
  import cdc_sync_pkg::*;

  localparam int             W       = 8;
  localparam int             DA      = 2;
  localparam int             DB      = 4;
  localparam int             FILTER  = DEFAULT_FILTER;
  localparam logic [W-1:0]   RST_VAL = '0;
  localparam int             HIST    = 16;
  localparam int             SB_W    = 3 * W + 1;
`ifdef MULTI_SYNC_FILTER_EN
  localparam bit             FILT_ON = 1'b1;
`else
  localparam bit             FILT_ON = 1'b0;
`endif
  localparam int             LAT_A   = DA + (FILT_ON ? FILTER : 0);
  localparam int             LAT_B   = DB + (FILT_ON ? FILTER : 0);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  multi_sync_edge_if #(.WIDTH(W)) bus_a ();
  multi_sync_edge_if #(.WIDTH(W)) bus_b ();

  multi_sync_edge #(.WIDTH(W), .DEPTH(DA), .FILTER(FILTER), .RST_VAL(RST_VAL)) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_a)
  );

  multi_sync_edge #(.WIDTH(W), .DEPTH(DB), .FILTER(FILTER), .RST_VAL(RST_VAL)) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_b)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[k] is the input value sampled k edges ago; each output is a pure
  // function of that history: plain delay, or "the last FILTER synced samples
  // all disagree with the current level".
  logic [W-1:0]      hist [HIST];
  logic [W-1:0]      lvl_a, lvl_b;
  logic [SB_W-1:0]   exp_a_q[$];
  logic [SB_W-1:0]   exp_b_q[$];

  function automatic logic [W-1:0] model_next(input int d, input logic [W-1:0] lvl);
    logic [W-1:0] nxt;
    logic         flip;
    if (!FILT_ON) return hist[d-1];
    nxt = lvl;
    for (int b = 0; b < W; b++) begin
      flip = 1'b1;
      for (int k = 0; k < FILTER; k++) begin
        if (hist[d+k][b] == lvl[b]) flip = 1'b0;
      end
      if (flip) nxt[b] = ~lvl[b];
    end
    return nxt;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < HIST; k++) hist[k] = RST_VAL;
    lvl_a = RST_VAL;
    lvl_b = RST_VAL;
    exp_a_q.delete();
    exp_b_q.delete();
  endtask

  always @(negedge rstn) model_reset();

  always @(posedge clk) begin
    logic [W-1:0] nxt;
    if (!rstn) begin
      model_reset();
    end else begin
      for (int k = HIST - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = bus_a.async_i;
      nxt = model_next(DA, lvl_a);
      exp_a_q.push_back({|(nxt ^ lvl_a), nxt & ~lvl_a, ~nxt & lvl_a, nxt});
      lvl_a = nxt;
      nxt = model_next(DB, lvl_b);
      exp_b_q.push_back({|(nxt ^ lvl_b), nxt & ~lvl_b, ~nxt & lvl_b, nxt});
      lvl_b = nxt;
    end
  end

  // ---------------- scoreboard (sampled on falling edge) ----------------
  int r_cnt [W];
  int f_cnt [W];

  initial for (int b = 0; b < W; b++) begin r_cnt[b] = 0; f_cnt[b] = 0; end

  always @(negedge clk) begin
    logic [SB_W-1:0] e;
    if (!rstn) begin
      check("a_rst_level", bus_a.level_o, RST_VAL);
      check("a_rst_rise",  bus_a.rise_o,  '0);
      check("a_rst_fall",  bus_a.fall_o,  '0);
      check("a_rst_any",   bus_a.any_edge_o, 1'b0);
      check("b_rst_level", bus_b.level_o, RST_VAL);
      check("b_rst_rise",  bus_b.rise_o,  '0);
      check("b_rst_fall",  bus_b.fall_o,  '0);
      check("b_rst_any",   bus_b.any_edge_o, 1'b0);
    end else begin
      if (exp_a_q.size() != 0) begin
        e = exp_a_q.pop_front();
        check("a_level", bus_a.level_o,    e[W-1:0]);
        check("a_fall",  bus_a.fall_o,     e[2*W-1:W]);
        check("a_rise",  bus_a.rise_o,     e[3*W-1:2*W]);
        check("a_any",   bus_a.any_edge_o, e[SB_W-1]);
      end
      if (exp_b_q.size() != 0) begin
        e = exp_b_q.pop_front();
        check("b_level", bus_b.level_o,    e[W-1:0]);
        check("b_fall",  bus_b.fall_o,     e[2*W-1:W]);
        check("b_rise",  bus_b.rise_o,     e[3*W-1:2*W]);
        check("b_any",   bus_b.any_edge_o, e[SB_W-1]);
      end
      check("a_rise_fall_excl", bus_a.rise_o & bus_a.fall_o, '0);
      check("b_rise_fall_excl", bus_b.rise_o & bus_b.fall_o, '0);
      for (int b = 0; b < W; b++) begin
        r_cnt[b] += int'(bus_a.rise_o[b]);
        f_cnt[b] += int'(bus_a.fall_o[b]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 3 time units after a rising edge, away from both sampling points.
  task automatic drive(input logic [W-1:0] v);
    bus_a.async_i = v;
    bus_b.async_i = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic apply(input logic [W-1:0] v, input int n);
    drive(v);
    cyc(n);
  endtask

  // Watches dut_a for the first cycle with any edge; reports its pulses and latency.
  task automatic first_edge(input int n, output logic [W-1:0] r, output logic [W-1:0] f,
                            output int at);
    r  = '0;
    f  = '0;
    at = -1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      if (at < 0 && bus_a.any_edge_o) begin
        r  = bus_a.rise_o;
        f  = bus_a.fall_o;
        at = c;
      end
    end
    cyc(1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int            ca, cb, rise_a_cyc, any_a_cyc, at, base_r, base_f;
    logic [W-1:0]  r, f;

    rstn = 1'b0;
    drive('1);
    cyc(3);
    check("rst_hold_level", bus_a.level_o, RST_VAL);
    check("rst_hold_any",   bus_a.any_edge_o, 1'b0);

    // Reset release with all inputs high: one rise per instance after its latency.
    rstn = 1'b1;
    ca = -1; cb = -1; rise_a_cyc = 0; any_a_cyc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (ca < 0 && bus_a.level_o == '1) ca = c;
      if (cb < 0 && bus_b.level_o == '1) cb = c;
      if (bus_a.rise_o == '1) rise_a_cyc++;
      if (bus_a.any_edge_o) any_a_cyc++;
    end
    check("rel_latency_a", ca, LAT_A);
    check("rel_latency_b", cb, LAT_B);
    check("rel_rise_cycles", rise_a_cyc, 1);
    check("rel_any_cycles",  any_a_cyc, 1);
    cyc(1);

    // Independent channels switching in the same cycle.
    apply('0, LAT_B + 4);
    drive(8'hA5);
    first_edge(LAT_B + 4, r, f, at);
    check("chan_a5_rise", r, 8'hA5);
    check("chan_a5_fall", f, 8'h00);
    check("chan_a5_lat",  at, LAT_A);
    drive(8'h5A);
    first_edge(LAT_B + 4, r, f, at);
    check("chan_5a_rise", r, 8'h5A);
    check("chan_5a_fall", f, 8'hA5);
    check("chan_5a_lat",  at, LAT_A);

    // Glitches on channel 3: 3 cycles (filtered when enabled), then 5 cycles.
    apply('0, LAT_B + 4);
    base_r = r_cnt[3]; base_f = f_cnt[3];
    apply(8'h08, 3);
    apply(8'h00, LAT_B + 6);
    check("glitch3_rise", r_cnt[3] - base_r, FILT_ON ? 0 : 1);
    check("glitch3_fall", f_cnt[3] - base_f, FILT_ON ? 0 : 1);
    base_r = r_cnt[3]; base_f = f_cnt[3];
    apply(8'h08, 5);
    apply(8'h00, LAT_B + 6);
    check("glitch5_rise", r_cnt[3] - base_r, 1);
    check("glitch5_fall", f_cnt[3] - base_f, 1);

    // Channel 0 toggling every cycle.
    base_r = r_cnt[0];
    for (int i = 0; i < 20; i++) apply((i % 2 == 0) ? 8'h01 : 8'h00, 1);
    apply('0, LAT_B + 6);
    check("toggle_rises", r_cnt[0] - base_r, FILT_ON ? 0 : 10);

    // Reset while channel 1 is in flight.
    apply('0, LAT_B + 4);
    drive(8'h02);
    cyc(2);
    rstn = 1'b0;
    #1;
    check("midrst_level1", bus_a.level_o[1], RST_VAL[1]);
    check("midrst_rise",   bus_a.rise_o, '0);
    cyc(2);
    base_r = r_cnt[1];
    rstn = 1'b1;
    cyc(LAT_B + 6);
    check("midrst_after_rise", r_cnt[1] - base_r, 1);

    // Random levels with random hold times.
    for (int i = 0; i < 400; i++) begin
      apply(W'($urandom), $urandom_range(1, 7));
    end
    apply(W'($urandom), LAT_B + 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_sync_edge.md
# multi_sync_edge

Multi-channel, parametrised synchroniser that brings WIDTH independent asynchronous level signals into the destination clock domain through a DEPTH-stage flop chain per channel. It adds an optional stability (glitch) filter and registered single-cycle rise/fall pulses per channel. It sits at the destination side of any control-signal crossing (status bits, requests, interrupt lines) and replaces per-bit hand-instantiated two-flop synchronisers.

## Interface
- WIDTH, 8, number of independent channels (≥1)
- DEPTH, 2, synchroniser stages per channel (≥2; elaboration error if <2)
- FILTER, 4, consecutive stable cycles required before the output accepts a new value (≥1; used only with the filter compiled in)
- RST_VAL, '0, WIDTH-bit reset value of every synchroniser stage, filter register and level_o
- clk  input  1  destination-domain clock; the only clock
- rstn  input  1  asynchronous, active-low reset
- async_i  input  WIDTH  asynchronous level inputs, one per channel
- level_o  output  WIDTH  synchronised (and filtered, if enabled) level
- rise_o  output  WIDTH  one-cycle pulse per channel when level_o goes 0→1
- fall_o  output  WIDTH  one-cycle pulse per channel when level_o goes 1→0
- any_edge_o  output  1  OR-reduction of rise_o | fall_o

## Operation
- Channels fully independent; no cross-channel coherency guaranteed (not for multi-bit buses).
- Per channel: s[0] samples async_i[i]; s[k] ← s[k-1]; synced value = s[DEPTH-1].
- Filter disabled: level_o[i] ← synced value each cycle.
- Filter enabled, per channel: counter cnt, width $clog2(FILTER+1).
  - synced == level_o: cnt ← 0.
  - synced != level_o and cnt == FILTER-1: level_o ← synced, cnt ← 0.
  - otherwise: cnt ← cnt+1 (saturating is not needed; never exceeds FILTER-1).
  - Any return of synced to level_o before acceptance clears cnt; glitches shorter than FILTER cycles never reach level_o.
- Edge pulses registered: rise_o[i] ← next_level & ~level_o; fall_o[i] ← ~next_level & level_o. A pulse is high exactly in the first cycle level_o shows the new value, low otherwise.
- any_edge_o combinational from registered rise_o/fall_o.

## Timing
- Reset (rstn low, asynchronous): all stages and level_o = RST_VAL; cnt = 0; rise_o = fall_o = 0; any_edge_o = 0.
- Reset deassertion: no pulses emitted by reset itself; if async_i differs from RST_VAL, the normal edge appears after standard latency.
- Latency, filter off: async_i stable before edge E → level_o and pulse change after edge E+DEPTH-1 (DEPTH edges).
- Latency, filter on: DEPTH + FILTER edges for a clean step.
- Input toggling every cycle with filter on: level_o never changes.
- Reset asserted mid-filter: counter and pending value discarded immediately.
- Simultaneous edges on several channels: each channel pulses independently in the same cycle.

## Configuration
- MULTI_SYNC_FILTER_EN defined: stability filter and counters present; FILTER active.
- Not defined: no counters, level_o is the last synchroniser stage, FILTER ignored; latency DEPTH edges.

## Structure
- Shared package cdc_sync_pkg: default constants (DEFAULT_SYNC_DEPTH = 2, DEFAULT_FILTER = 4) and a counter-width function cnt_w(FILTER).
- Sub-module sync_chan: one channel (sync chain, optional filter, edge registers); top generates WIDTH instances and the any_edge_o OR.

## Test plan
- Reset: rstn low with async_i = 8'hFF, RST_VAL = 0 → all outputs 0; after release, level_o = 8'hFF after DEPTH (filter off) or DEPTH+FILTER (filter on) edges, rise_o = 8'hFF for exactly one cycle, any_edge_o high one cycle.
- Latency sweep: DEPTH = 2, 3, 4, filter off; step async_i[0] 0→1 → level_o[0] rises after exactly DEPTH edges, rise_o[0] single pulse aligned to it.
- Glitch reject: filter on, FILTER = 4; pulse async_i[3] high for 3 cycles → level_o[3] stays 0, no rise/fall; pulse 5 cycles → rise after DEPTH+4 edges, fall after same latency from falling edge.
- Independent channels: async_i 8'h00→8'hA5 in one cycle → rise_o = 8'hA5 in one cycle, fall_o = 0; then 8'hA5→8'h5A → rise_o = 8'h5A, fall_o = 8'hA5 same cycle.
- Mid-operation reset: filter on, step async_i[1] and assert rstn after 2 cycles → level_o[1] = RST_VAL[1], no pulses during or immediately after reset.
- Random async_i with randomised setup → level_o equals reference model (ideal delay DEPTH[+FILTER]) after any settle window; rise_o/fall_o never both high on one channel.
